// File: rtl/logic_unit_seq.sv
// Registered WIDTH-bit two-operand logic unit with valid/ready handshakes
// and a built-in truth-table sweep source.
module logic_unit_seq #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [2:0]       out_op,
   output logic [WIDTH-1:0] s
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] ca_q;
   logic [WIDTH-1:0] cb_q;
   logic [2:0]       sweep_op_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_a_q;
   logic [WIDTH-1:0] out_b_q;
   logic [2:0]       out_op_q;
   logic [WIDTH-1:0] s_q;

   logic             load;
   logic             ext_take;
   logic             src_valid;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [2:0]       src_op;
   logic             last_pair;

   function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      case (f)
         3'b000:  r = x & y;
         3'b001:  r = x | y;
         3'b010:  r = ~(x & y);
         3'b011:  r = ~(x | y);
         3'b100:  r = x ^ y;
         3'b101:  r = ~(x ^ y);
         3'b110:  r = x | ~y;
         default: r = ~x | y;
      endcase
      return r;
   endfunction

   // Source selection: the sweep counters own the output stage while sweeping.
   always_comb begin
      load      = ~out_valid_q | out_ready;
      in_ready  = load & (state_q == IDLE) & ~sweep_start & ~reset;
      ext_take  = in_valid & in_ready;
      src_valid = (state_q == SWEEP) | ext_take;
      src_a     = (state_q == SWEEP) ? ca_q : a;
      src_b     = (state_q == SWEEP) ? cb_q : b;
      src_op    = (state_q == SWEEP) ? sweep_op_q : op;
      last_pair = (ca_q == {WIDTH{1'b1}}) & (cb_q == {WIDTH{1'b1}});
      sweep_done = (state_q == DRAIN) & out_valid_q & out_ready & ~reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ca_q        <= '0;
         cb_q        <= '0;
         sweep_op_q  <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_op_q    <= '0;
         s_q         <= '0;
      end else begin
         if (load) begin
            out_valid_q <= src_valid;
            if (src_valid) begin
               out_a_q  <= src_a;
               out_b_q  <= src_b;
               out_op_q <= src_op;
               s_q      <= gate_f(src_op, src_a, src_b);
            end
         end
         case (state_q)
            IDLE: begin
               if (sweep_start) begin
                  sweep_op_q <= op;
                  ca_q       <= '0;
                  cb_q       <= '0;
                  state_q    <= SWEEP;
               end
            end
            SWEEP: begin
               // cb is the inner counter; ca steps on cb wrap
               if (load) begin
                  cb_q <= cb_q + WIDTH'(1);
                  if (cb_q == {WIDTH{1'b1}}) ca_q <= ca_q + WIDTH'(1);
                  if (last_pair) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_valid_q & out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sweep_busy = (state_q != IDLE);
   assign out_valid  = out_valid_q;
   assign out_a      = out_a_q;
   assign out_b      = out_b_q;
   assign out_op     = out_op_q;
   assign s          = s_q;

endmodule
